// File: rtl/ssd_pkg.sv
// Shared constants, encodings and segment lookup for the seven-segment scan controller.
package ssd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL   = 8'hFF;
  localparam logic [7:0] SEG_GAME  = 8'h49;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam logic [31:0] BCD_ALL9  = 32'h9999_9999;

  typedef enum logic [1:0] {
    MODE_SCORE = 2'd0,
    MODE_GAME  = 2'd1,
    MODE_TEST  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Active-high segment code; anything outside 0-9 is blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] seg_encode_zblank(input logic [3:0] d);
    return (d == 4'd0) ? SEG_BLANK : seg_encode(d);
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_bin2bcd.sv
// Sequential 32-bit binary to 8-digit BCD converter (shift-add-3), one bit per clock.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [31:0] bcd,
  output logic        ovf
);

  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [31:0] adj;
  logic [5:0]  cnt_q;
  logic        run_q;
  logic        ovf_q;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 8; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // A bit leaving the top digit means the value needs a ninth digit, i.e. > 99_999_999.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= 6'd32;
      run_q <= 1'b1;
      ovf_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= {adj[30:0], bin_q[31]};
      bin_q <= {bin_q[30:0], 1'b0};
      ovf_q <= ovf_q | adj[31];
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) run_q <= 1'b0;
    end
  end

  // done marks the final shift; bcd/ovf are settled from the following cycle.
  assign done = run_q && (cnt_q == 6'd1);
  assign bcd  = ovf_q ? BCD_ALL9 : bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: digit-scan timing, source arbitration, BCD conversion, pin drive.
//   state   | meaning
//   ST_IDLE | waiting for frame_start; display registers stable
//   ST_CONV | 32 shift-add-3 cycles in progress
//   ST_LOAD | one cycle: copy BCD result, mode, game digit and overflow to display
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int BCD_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [3:0]  game_d,
  input  logic        game,
  input  logic        test,
  output logic [7:0]  seg_data_0_pin,
  output logic [7:0]  seg_data_1_pin,
  output logic [7:0]  seg_cs_pin,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic          scan_tick;
  logic          frame_start;
  logic [3:0]    sel_q;
  logic [3:0]    sel_nxt;

  state_t state_q, state_nxt;
  logic   conv_start;
  logic   load_en;
  mode_t  mode_req;

  mode_t                   mode_smp_q;
  logic [3:0]              game_d_smp_q;
  mode_t                   disp_mode_q;
  logic [3:0]              disp_game_d_q;
  logic [4*BCD_DIGITS-1:0] disp_bcd_q;

  logic [31:0] conv_bcd;
  logic        conv_done;
  logic        conv_ovf;

  logic [1:0] slot;
  logic [3:0] b0_dig;
  logic [3:0] b1_dig;
  logic [7:0] seg0_nxt;
  logic [7:0] seg1_nxt;

  assign scan_tick   = (presc_q == PW'(SCAN_DIV - 1));
  assign sel_nxt     = {sel_q[2:0], sel_q[3]};
  assign frame_start = scan_tick && sel_q[3];
  assign busy        = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      sel_q          <= 4'b0001;
      seg_cs_pin     <= 8'h11;
      seg_data_0_pin <= SEG_BLANK;
      seg_data_1_pin <= SEG_BLANK;
    end else begin
      presc_q <= scan_tick ? '0 : presc_q + PW'(1);
      if (scan_tick) begin
        sel_q          <= sel_nxt;
        seg_cs_pin     <= {sel_nxt, sel_nxt};
        seg_data_0_pin <= seg0_nxt;
        seg_data_1_pin <= seg1_nxt;
      end
    end
  end

  always_comb begin
    mode_req = MODE_SCORE;
    if (test)      mode_req = MODE_TEST;
    else if (game) mode_req = MODE_GAME;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    conv_start = 1'b0;
    load_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          conv_start = 1'b1;
          state_nxt  = ST_CONV;
        end
      end
      ST_CONV: if (conv_done) state_nxt = ST_LOAD;
      ST_LOAD: begin
        load_en   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (value),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Mode and game digit ride alongside the conversion so the whole frame switches at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_smp_q    <= MODE_SCORE;
      game_d_smp_q  <= BCD_BLANK;
      disp_mode_q   <= MODE_SCORE;
      disp_game_d_q <= BCD_BLANK;
      disp_bcd_q    <= {BCD_DIGITS{BCD_BLANK}};
      overflow      <= 1'b0;
    end else begin
      if (conv_start) begin
        mode_smp_q   <= mode_req;
        game_d_smp_q <= game_d;
      end
      if (load_en) begin
        disp_mode_q   <= mode_smp_q;
        disp_game_d_q <= game_d_smp_q;
        disp_bcd_q    <= conv_bcd;
        overflow      <= conv_ovf;
      end
    end
  end

  always_comb begin
    slot = 2'd0;
    if (sel_nxt[1]) slot = 2'd1;
    if (sel_nxt[2]) slot = 2'd2;
    if (sel_nxt[3]) slot = 2'd3;
  end

  // bank0 slot i shows BCD[7-i], bank1 slot i shows BCD[3-i].
  assign b0_dig = disp_bcd_q[{1'b1, ~slot, 2'b00} +: 4];
  assign b1_dig = disp_bcd_q[{1'b0, ~slot, 2'b00} +: 4];

  always_comb begin
    seg0_nxt = SEG_BLANK;
    seg1_nxt = SEG_BLANK;
    case (disp_mode_q)
      MODE_TEST: begin
        seg0_nxt = SEG_ALL;
        seg1_nxt = SEG_ALL;
      end
      MODE_GAME: begin
        seg1_nxt = seg_encode_zblank(b1_dig);
        case (slot)
          2'd0:    seg0_nxt = seg_encode_zblank(disp_game_d_q);
          2'd1:    seg0_nxt = SEG_GAME;
          default: seg0_nxt = seg_encode_zblank(b0_dig);
        endcase
      end
      default: begin
        seg0_nxt = seg_encode(b0_dig);
        seg1_nxt = seg_encode(b1_dig);
      end
    endcase
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: stimulus queues expected slot contents, a monitor checks each slot.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic [3:0]  game_d = '0;
  logic        game = 1'b0;
  logic        test = 1'b0;
  logic [7:0]  seg_data_0_pin;
  logic [7:0]  seg_data_1_pin;
  logic [7:0]  seg_cs_pin;
  logic        busy;
  logic        overflow;

  ssd_scan_ctrl #(.SCAN_DIV(16), .BCD_DIGITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .value          (value),
    .game_d         (game_d),
    .game           (game),
    .test           (test),
    .seg_data_0_pin (seg_data_0_pin),
    .seg_data_1_pin (seg_data_1_pin),
    .seg_cs_pin     (seg_cs_pin),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cs;
    logic [7:0] s0;
    logic [7:0] s1;
    string      tag;
  } slot_t;

  slot_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic push1(input logic [7:0] cs, input logic [7:0] s0, input logic [7:0] s1,
                       input string tag);
    slot_t e;
    e.cs  = cs;
    e.s0  = s0;
    e.s1  = s1;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // b0/b1 hold slots 0..3 from MSB byte to LSB byte.
  task automatic push_frame(input logic [31:0] b0, input logic [31:0] b1, input string tag);
    logic [7:0] cs;
    for (int i = 0; i < 4; i++) begin
      cs = 8'h11;
      cs = cs << i;
      push1(cs, b0[31-8*i -: 8], b1[31-8*i -: 8], $sformatf("%s_slot%0d", tag, i));
    end
  endtask

  task automatic wait_arrival(input logic [7:0] cs);
    logic [7:0] p;
    p = seg_cs_pin;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (seg_cs_pin == cs && p != cs) return;
      p = seg_cs_pin;
    end
    n_checks++;
    $display("FAIL wait_cs_%h: slot did not arrive within 300 cycles, cs=%h", cs, seg_cs_pin);
  endtask

  task automatic measure_busy();
    int len;
    int n;
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    len = 0;
    while (busy && len < 100) begin
      len++;
      @(negedge clk);
    end
    chk("busy_len", len, 33);
  endtask

  // Applies inputs, lets them be sampled and converted, then checks one full stable frame.
  task automatic show(input logic t, input logic g, input logic [31:0] v, input logic [3:0] gd,
                      input logic [31:0] b0, input logic [31:0] b1, input string tag);
    test   = t;
    game   = g;
    value  = v;
    game_d = gd;
    wait_arrival(8'h88);
    wait_arrival(8'h88);
    @(posedge clk);
    push_frame(b0, b1, tag);
    wait_arrival(8'h88);
  endtask

  initial begin : monitor
    logic [7:0] prev;
    slot_t      e;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && seg_cs_pin !== prev && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, "_cs"},   {24'h0, seg_cs_pin},     {24'h0, e.cs});
        chk({e.tag, "_seg0"}, {24'h0, seg_data_0_pin}, {24'h0, e.s0});
        chk({e.tag, "_seg1"}, {24'h0, seg_data_1_pin}, {24'h0, e.s1});
      end
      prev = seg_cs_pin;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs",       {24'h0, seg_cs_pin},     32'h11);
    chk("rst_seg0",     {24'h0, seg_data_0_pin}, 32'h00);
    chk("rst_seg1",     {24'h0, seg_data_1_pin}, 32'h00);
    chk("rst_busy",     {31'h0, busy},           32'h0);
    chk("rst_overflow", {31'h0, overflow},       32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    value = 32'd12345678;
    measure_busy();
    show(1'b0, 1'b0, 32'd12345678, 4'd0, 32'h065B4F66, 32'h6D7D077F, "score_12345678");
    show(1'b0, 1'b1, 32'd120000,   4'd3, 32'h4F49065B, 32'h00000000, "game_120000");
    show(1'b0, 1'b1, 32'd5040302,  4'd0, 32'h00490066, 32'h004F005B, "game_zero_blank");
    show(1'b1, 1'b1, 32'd120000,   4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "test_over_game");
    show(1'b0, 1'b1, 32'd120000,   4'd3, 32'h4F49065B, 32'h00000000, "test_released");
    show(1'b0, 1'b0, 32'd100000000, 4'd0, 32'h6F6F6F6F, 32'h6F6F6F6F, "overflow_100m");
    chk("overflow_set", {31'h0, overflow}, 32'h1);
    show(1'b0, 1'b0, 32'd99999999, 4'd0, 32'h6F6F6F6F, 32'h6F6F6F6F, "max_99999999");
    chk("overflow_max", {31'h0, overflow}, 32'h0);
    show(1'b0, 1'b0, 32'd0,         4'd0, 32'h3F3F3F3F, 32'h3F3F3F3F, "zero");
    chk("overflow_clr", {31'h0, overflow}, 32'h0);

    // Value change in slot 2: old data holds until the conversion of the next frame lands.
    show(1'b0, 1'b0, 32'd87654321, 4'd0, 32'h7F077D6D, 32'h664F5B06, "mid_old");
    wait_arrival(8'h44);
    @(posedge clk);
    value = 32'd90817;
    push1(8'h88, 8'h6D, 8'h06, "mid_hold_d3");
    push1(8'h11, 8'h7F, 8'h66, "mid_hold_e0");
    push1(8'h22, 8'h07, 8'h4F, "mid_hold_e1");
    push1(8'h44, 8'h7D, 8'h5B, "mid_hold_e2");
    push1(8'h88, 8'h6F, 8'h07, "mid_new_e3");
    push_frame(32'h3F3F3F6F, 32'h3F7F0607, "mid_new");
    repeat (3) wait_arrival(8'h88);

    // Reset ten clocks into a conversion.
    value = 32'd12345678;
    wait_arrival(8'h88);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",     {31'h0, busy},           32'h0);
    chk("abort_cs",       {24'h0, seg_cs_pin},     32'h11);
    chk("abort_seg0",     {24'h0, seg_data_0_pin}, 32'h00);
    chk("abort_seg1",     {24'h0, seg_data_1_pin}, 32'h00);
    chk("abort_overflow", {31'h0, overflow},       32'h0);
    @(posedge clk);
    push1(8'h22, 8'h00, 8'h00, "abort_r1_1");
    push1(8'h44, 8'h00, 8'h00, "abort_r1_2");
    push1(8'h88, 8'h00, 8'h00, "abort_r1_3");
    push1(8'h11, 8'h00, 8'h00, "abort_r2_0");
    push1(8'h22, 8'h00, 8'h00, "abort_r2_1");
    push1(8'h44, 8'h00, 8'h00, "abort_r2_2");
    push1(8'h88, 8'h66, 8'h7F, "abort_r2_3");
    push_frame(32'h065B4F66, 32'h6D7D077F, "abort_r3");
    repeat (3) wait_arrival(8'h88);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
